// File: rtl/apple2_io_controller_pkg.sv
// Shared constants and types for the Apple II I/O page controller.
// Optional feature macro: APPLE2_EXPANSION_ROM_EN (see apple2_io_controller).
package apple2_io_pkg;

  // Base addresses of the decoded I/O windows
  localparam logic [15:0] KBD_BASE     = 16'hC000;
  localparam logic [15:0] KBDSTRB_BASE = 16'hC010;
  localparam logic [15:0] SPKR_BASE    = 16'hC030;
  localparam logic [15:0] SWITCH_BASE  = 16'hC050;
  localparam logic [15:0] DEVSEL_BASE  = 16'hC080;
  localparam logic [15:0] IOSEL_BASE   = 16'hC100;
  localparam logic [15:0] EXPROM_BASE  = 16'hC800;
  localparam logic [15:0] EXPROM_OFF   = 16'hCFFF;

  // Soft-switch bit positions
  localparam int SW_TEXT  = 0;
  localparam int SW_MIX   = 1;
  localparam int SW_PAGE2 = 2;
  localparam int SW_HIRES = 3;

  typedef logic [2:0] slot_idx_t;

endpackage

// File: rtl/apple2_kbd_latch.sv
// Keyboard code latch with strobe; a new key always beats a strobe clear.
module apple2_kbd_latch
  import apple2_io_pkg::*;
#(
  parameter int KBD_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [KBD_WIDTH-1:0] key_code,
  input  logic                 strobe_clr,
  output logic [KBD_WIDTH-1:0] key_latch,
  output logic                 kbd_strobe
);

  logic [KBD_WIDTH-1:0] key_d, key_q;
  logic                 strobe_d, strobe_q;

  // Next-state: key arrival sets strobe and overrides a same-clock clear
  always_comb begin
    key_d    = key_q;
    strobe_d = strobe_q;
    if (strobe_clr) strobe_d = 1'b0;
    if (key_valid) begin
      key_d    = key_code;
      strobe_d = 1'b1;
    end
  end

  // Latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      strobe_q <= strobe_d;
    end
  end

  assign key_latch  = key_q;
  assign kbd_strobe = strobe_q;

endmodule

// File: rtl/apple2_io_controller.sv
// Apple II $C000-$CFFF I/O page controller: keyboard, speaker, soft switches,
// slot device/io select pulses. Commits happen on Clock_14Mhz edges with cycle_en.
// Optional feature macro: APPLE2_EXPANSION_ROM_EN adds expansion-ROM tracking
// (exp_rom_slot, exp_rom_active, io_strobe); without it $C800-$CFFF is unmapped.
module apple2_io_controller
  import apple2_io_pkg::*;
#(
  parameter int          NUM_SLOTS    = 8,
  parameter int          NUM_SWITCHES = 8,
  parameter int          KBD_WIDTH    = 7,
  parameter logic [7:0]  SWITCH_RESET = 8'h00
) (
  input  logic                    Clock_14Mhz,
  input  logic                    RESET_N,
  input  logic                    cycle_en,
  input  logic [15:0]             cpu_addr,
  input  logic                    cpu_we,
  input  logic [KBD_WIDTH-1:0]    key_code,
  input  logic                    key_valid,
  output logic [7:0]              io_rd_data,
  output logic                    io_rd_valid,
  output logic [NUM_SWITCHES-1:0] soft_switches,
  output logic                    speaker,
  output logic [NUM_SLOTS-1:0]    device_select,
  output logic [NUM_SLOTS-1:0]    io_select
`ifdef APPLE2_EXPANSION_ROM_EN
  ,
  output logic [2:0]              exp_rom_slot,
  output logic                    exp_rom_active,
  output logic                    io_strobe
`endif
);

  // Reads and writes decode identically
  logic unused_we;
  assign unused_we = cpu_we;

  logic                    hit_kbd, hit_strb, hit_spkr, hit_sw, hit_dev, hit_io;
  slot_idx_t               dev_slot, io_slot;
  logic [2:0]              sw_idx;
  logic [KBD_WIDTH-1:0]    key_latch;
  logic                    kbd_strobe;
  logic [6:0]              key7;

  logic [NUM_SWITCHES-1:0] sw_d, sw_q;
  logic                    spk_d, spk_q;
  logic [NUM_SLOTS-1:0]    dev_d, dev_q;
  logic [NUM_SLOTS-1:0]    ios_d, ios_q;

  // Address window decode, purely combinational on cpu_addr
  always_comb begin
    hit_kbd  = (cpu_addr[15:4]  == KBD_BASE[15:4]);
    hit_strb = (cpu_addr[15:4]  == KBDSTRB_BASE[15:4]);
    hit_spkr = (cpu_addr[15:4]  == SPKR_BASE[15:4]);
    hit_sw   = (cpu_addr[15:4]  == SWITCH_BASE[15:4]);
    hit_dev  = (cpu_addr[15:7]  == DEVSEL_BASE[15:7]);
    // $C000-$C7FF with a nonzero slot nibble; slot 0 has no io_select window
    hit_io   = (cpu_addr[15:11] == IOSEL_BASE[15:11]) && (cpu_addr[10:8] != 3'd0);
    dev_slot = cpu_addr[6:4];
    io_slot  = cpu_addr[10:8];
    sw_idx   = cpu_addr[3:1];
  end

  apple2_kbd_latch #(.KBD_WIDTH(KBD_WIDTH)) u_kbd (
    .clk        (Clock_14Mhz),
    .rst_n      (RESET_N),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .strobe_clr (cycle_en && hit_strb),
    .key_latch  (key_latch),
    .kbd_strobe (kbd_strobe)
  );

  assign key7 = 7'(key_latch);

  // Internal read mux: only the keyboard windows return data
  always_comb begin
    io_rd_data  = 8'h00;
    io_rd_valid = 1'b0;
    if (hit_kbd) begin
      io_rd_data  = {kbd_strobe, key7};
      io_rd_valid = 1'b1;
    end else if (hit_strb) begin
      io_rd_data  = {1'b0, key7};
      io_rd_valid = 1'b1;
    end
  end

  // Next-state for switches/speaker and one-hot select pulses; loops bound the
  // slot/switch index so out-of-range indices simply match nothing
  always_comb begin
    sw_d  = sw_q;
    spk_d = spk_q;
    dev_d = '0;
    ios_d = '0;
    if (cycle_en) begin
      if (hit_spkr) spk_d = ~spk_q;
      for (int i = 0; i < NUM_SWITCHES; i++)
        if (hit_sw && sw_idx == 3'(i)) sw_d[i] = cpu_addr[0];
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (hit_dev && dev_slot == 3'(i)) dev_d[i] = 1'b1;
        if (hit_io  && io_slot  == 3'(i)) ios_d[i] = 1'b1;
      end
    end
  end

  // Committed state and registered select pulses
  always_ff @(posedge Clock_14Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_q  <= SWITCH_RESET[NUM_SWITCHES-1:0];
      spk_q <= 1'b0;
      dev_q <= '0;
      ios_q <= '0;
    end else begin
      sw_q  <= sw_d;
      spk_q <= spk_d;
      dev_q <= dev_d;
      ios_q <= ios_d;
    end
  end

  assign soft_switches = sw_q;
  assign speaker       = spk_q;
  assign device_select = dev_q;
  assign io_select     = ios_q;

`ifdef APPLE2_EXPANSION_ROM_EN
  logic       hit_exp;
  logic       exp_act_d, exp_act_q;
  logic [2:0] exp_slot_d, exp_slot_q;
  logic       iostb_d, iostb_q;

  assign hit_exp = (cpu_addr[15:11] == EXPROM_BASE[15:11]);

  // Expansion ROM ownership: io_select commit claims it, $CFFF releases (wins)
  always_comb begin
    exp_act_d  = exp_act_q;
    exp_slot_d = exp_slot_q;
    iostb_d    = 1'b0;
    if (cycle_en) begin
      if (|ios_d) begin
        exp_act_d  = 1'b1;
        exp_slot_d = io_slot;
      end
      if (cpu_addr == EXPROM_OFF) exp_act_d = 1'b0;
      iostb_d = hit_exp;
    end
  end

  // Expansion ROM registers
  always_ff @(posedge Clock_14Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      exp_act_q  <= 1'b0;
      exp_slot_q <= 3'd0;
      iostb_q    <= 1'b0;
    end else begin
      exp_act_q  <= exp_act_d;
      exp_slot_q <= exp_slot_d;
      iostb_q    <= iostb_d;
    end
  end

  assign exp_rom_active = exp_act_q;
  assign exp_rom_slot   = exp_slot_q;
  assign io_strobe      = iostb_q;
`endif

endmodule
